// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard/stall controller:
//   the sequencing FSM state encoding, the register-zero specifier and the
//   canned control vectors driven onto the pipeline-register enables.
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  // Writes to register zero are discarded, so a load targeting it never
  // creates a real dependency.
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_hold;
  } ctrl_t;

  // Free-running pipeline: everything advances, nothing squashed.
  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1,
                                     ifid_flush: 1'b0, idex_flush: 1'b0,
                                     exmem_hold: 1'b0};

  // Held during reset: front end frozen, both front registers load bubbles.
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                   ifid_flush: 1'b1, idex_flush: 1'b1,
                                   exmem_hold: 1'b0};

  // Load-use bubble: PC and IF/ID hold, ID/EX receives a bubble.
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0,
                                   ifid_flush: 1'b0, idex_flush: 1'b1,
                                   exmem_hold: 1'b0};

  // Taken-branch squash: PC loads the target, wrong-path IF/ID and ID/EX die.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1,
                                   ifid_flush: 1'b1, idex_flush: 1'b1,
                                   exmem_hold: 1'b0};

  // Data-memory wait: the whole pipeline freezes, nothing is squashed.
  localparam ctrl_t CTRL_MEM = '{pc_write: 1'b0, ifid_write: 1'b0,
                                 ifid_flush: 1'b0, idex_flush: 1'b0,
                                 exmem_hold: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   W-bit event counter that sticks at all-ones. A synchronous clear wins over
//   an increment in the same cycle.
//   Ports: clk, rst_n (async active-low), clr (sync clear), inc (count this
//   cycle), count (current value).
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//   Sequencing controller for the 5-stage pipeline. Handles what EX forwarding
//   cannot: load-use stalls, taken-branch flushes, ID-stage jump squashes and
//   data-memory wait states. Priority: memBusy > branchTakenEX > load-use >
//   jumpID. Control outputs are combinational so they act in the hazard cycle.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     regRsID, regRtID, useRtID       source operands of the ID instruction
//     memReadEX, writeRegEX           load/destination of the EX instruction
//     branchTakenEX, jumpID, memBusy  control-flow and memory-wait events
//     cntClr                          synchronous clear of both counters
//     pcWrite, ifidWrite              front-end load enables
//     ifidFlush, idexFlush            bubble insertion
//     exmemHold                       back-end freeze
//     stateOut                        FSM state for debug
//     stallCount, flushCount          saturating profiling counters
// -----------------------------------------------------------------------------
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W               = 5,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] regRsID,
  input  logic [REG_W-1:0] regRtID,
  input  logic             useRtID,
  input  logic             memReadEX,
  input  logic [REG_W-1:0] writeRegEX,
  input  logic             branchTakenEX,
  input  logic             jumpID,
  input  logic             memBusy,
  input  logic             cntClr,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemHold,
  output logic [1:0]       stateOut,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int MAX_CYC = (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
                           LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
  localparam int REM_W   = $clog2(MAX_CYC + 1);

  localparam logic [REM_W-1:0] REM_ONE       = REM_W'(1);
  localparam logic [REM_W-1:0] LOAD_RELOAD   = REM_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [REM_W-1:0] BRANCH_RELOAD = REM_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [REG_W-1:0] REG_Z         = REG_W'(REG_ZERO);

  state_t           state, state_nxt, saved_state, eff_state;
  logic [REM_W-1:0] rem_cnt, rem_nxt, saved_rem, eff_rem;
  logic             load_haz;
  ctrl_t            ctrl, ctrl_out;

  assign load_haz = memReadEX && (writeRegEX != REG_Z) &&
                    ((writeRegEX == regRsID) ||
                     (useRtID && (writeRegEX == regRtID)));

  // The cycle memBusy drops is evaluated as the interrupted state, so the
  // saved context stands in for the live one while in MEM_WAIT.
  assign eff_state = (state == MEM_WAIT) ? saved_state : state;
  assign eff_rem   = (state == MEM_WAIT) ? saved_rem   : rem_cnt;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_nxt = RUN;
    rem_nxt   = '0;

    if (memBusy) begin
      ctrl      = CTRL_MEM;
      state_nxt = MEM_WAIT;
      rem_nxt   = rem_cnt;
    end else if (branchTakenEX) begin
      // Same action from RUN, an aborted LOAD_STALL, or a FLUSH reload.
      ctrl = CTRL_FLUSH;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        rem_nxt   = BRANCH_RELOAD;
      end
    end else begin
      case (eff_state)
        LOAD_STALL: begin
          ctrl = CTRL_STALL;
          if (eff_rem != REM_ONE) begin
            state_nxt = LOAD_STALL;
            rem_nxt   = eff_rem - REM_ONE;
          end
        end
        FLUSH: begin
          ctrl = CTRL_FLUSH;
          if (eff_rem != REM_ONE) begin
            state_nxt = FLUSH;
            rem_nxt   = eff_rem - REM_ONE;
          end
        end
        default: begin
          if (load_haz) begin
            // A jump in ID is simply held in IF/ID and re-presented.
            ctrl = CTRL_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LOAD_STALL;
              rem_nxt   = LOAD_RELOAD;
            end
          end else if (jumpID) begin
            ctrl.ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      rem_cnt     <= '0;
      saved_state <= RUN;
      saved_rem   <= '0;
    end else begin
      state   <= state_nxt;
      rem_cnt <= rem_nxt;
      // Capture context only on entry; a stretched wait keeps the original.
      if (memBusy && (state != MEM_WAIT)) begin
        saved_state <= state;
        saved_rem   <= rem_cnt;
      end
    end
  end

  assign ctrl_out  = rst_n ? ctrl : CTRL_RESET;
  assign pcWrite   = ctrl_out.pc_write;
  assign ifidWrite = ctrl_out.ifid_write;
  assign ifidFlush = ctrl_out.ifid_flush;
  assign idexFlush = ctrl_out.idex_flush;
  assign exmemHold = ctrl_out.exmem_hold;
  assign stateOut  = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cntClr),
    .inc   (~ctrl_out.pc_write),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cntClr),
    .inc   (ctrl_out.ifid_flush | ctrl_out.idex_flush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_controller
//   Two instances share one stimulus stream: dut_a uses the default
//   parameters, dut_b uses LOAD_STALL_CYCLES=3, BRANCH_FLUSH_CYCLES=2 and
//   3-bit counters so multi-cycle sequences and saturation are reachable.
//   Control vectors are packed {pcWrite, ifidWrite, ifidFlush, idexFlush,
//   exmemHold}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam logic [4:0] V_DEF   = 5'b11000;
  localparam logic [4:0] V_RST   = 5'b00110;
  localparam logic [4:0] V_STALL = 5'b00010;
  localparam logic [4:0] V_FLUSH = 5'b11110;
  localparam logic [4:0] V_MEM   = 5'b00001;
  localparam logic [4:0] V_JUMP  = 5'b11100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] regRsID = '0, regRtID = '0, writeRegEX = '0;
  logic       useRtID = 1'b0, memReadEX = 1'b0, branchTakenEX = 1'b0;
  logic       jumpID = 1'b0, memBusy = 1'b0, cntClr = 1'b0;

  logic        a_pc, a_ifw, a_iff, a_idf, a_hold;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifw, b_iff, b_idf, b_hold;
  logic [1:0]  b_state;
  logic [2:0]  b_stall, b_flush;
  logic [4:0]  a_ctrl, b_ctrl;

  assign a_ctrl = {a_pc, a_ifw, a_iff, a_idf, a_hold};
  assign b_ctrl = {b_pc, b_ifw, b_iff, b_idf, b_hold};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut_a (
    .clk(clk), .rst_n(rst_n), .regRsID(regRsID), .regRtID(regRtID),
    .useRtID(useRtID), .memReadEX(memReadEX), .writeRegEX(writeRegEX),
    .branchTakenEX(branchTakenEX), .jumpID(jumpID), .memBusy(memBusy),
    .cntClr(cntClr), .pcWrite(a_pc), .ifidWrite(a_ifw), .ifidFlush(a_iff),
    .idexFlush(a_idf), .exmemHold(a_hold), .stateOut(a_state),
    .stallCount(a_stall), .flushCount(a_flush)
  );

  hazard_stall_controller #(
    .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .regRsID(regRsID), .regRtID(regRtID),
    .useRtID(useRtID), .memReadEX(memReadEX), .writeRegEX(writeRegEX),
    .branchTakenEX(branchTakenEX), .jumpID(jumpID), .memBusy(memBusy),
    .cntClr(cntClr), .pcWrite(b_pc), .ifidWrite(b_ifw), .ifidFlush(b_iff),
    .idexFlush(b_idf), .exmemHold(b_hold), .stateOut(b_state),
    .stallCount(b_stall), .flushCount(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic look();
    #1;
  endtask

  task automatic quiet();
    regRsID = '0; regRtID = '0; writeRegEX = '0; useRtID = 1'b0;
    memReadEX = 1'b0; branchTakenEX = 1'b0; jumpID = 1'b0; memBusy = 1'b0;
  endtask

  task automatic idle_clear();
    quiet();
    for (int i = 0; i < 4; i++) cyc();
    cntClr = 1'b1;
    cyc();
    cntClr = 1'b0;
  endtask

  task automatic load_use();
    memReadEX = 1'b1; writeRegEX = 5'd8; regRsID = 5'd8;
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_ctrl", 32'(a_ctrl), 32'(V_RST));
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_flush", 32'(a_flush), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    look();
    check("post_rst_ctrl", 32'(a_ctrl), 32'(V_DEF));

    // Load-use on rs: single bubble with default parameters.
    load_use();
    look();
    check("lu_ctrl", 32'(a_ctrl), 32'(V_STALL));
    cyc();
    quiet();
    look();
    check("lu_after_ctrl", 32'(a_ctrl), 32'(V_DEF));
    check("lu_stall", 32'(a_stall), 32'd1);
    check("lu_flush", 32'(a_flush), 32'd1);
    idle_clear();

    // Register zero and rt qualification.
    memReadEX = 1'b1; useRtID = 1'b1;
    look();
    check("r0_a", 32'(a_ctrl), 32'(V_DEF));
    check("r0_b", 32'(b_ctrl), 32'(V_DEF));
    writeRegEX = 5'd8; regRsID = 5'd3; regRtID = 5'd8; useRtID = 1'b0;
    look();
    check("rt_unused", 32'(a_ctrl), 32'(V_DEF));
    useRtID = 1'b1;
    look();
    check("rt_used", 32'(a_ctrl), 32'(V_STALL));
    jumpID = 1'b1;
    look();
    check("lu_and_jump", 32'(a_ctrl), 32'(V_STALL));
    memReadEX = 1'b0;
    look();
    check("jump_only", 32'(a_ctrl), 32'(V_JUMP));
    idle_clear();

    // Taken branch: dut_b flushes two cycles, dut_a one.
    branchTakenEX = 1'b1;
    look();
    check("br0_b_ctrl", 32'(b_ctrl), 32'(V_FLUSH));
    check("br0_b_state", 32'(b_state), 32'd0);
    check("br0_a_ctrl", 32'(a_ctrl), 32'(V_FLUSH));
    cyc();
    branchTakenEX = 1'b0;
    look();
    check("br1_b_ctrl", 32'(b_ctrl), 32'(V_FLUSH));
    check("br1_b_state", 32'(b_state), 32'd2);
    check("br1_a_ctrl", 32'(a_ctrl), 32'(V_DEF));
    cyc();
    look();
    check("br2_b_ctrl", 32'(b_ctrl), 32'(V_DEF));
    check("br2_b_state", 32'(b_state), 32'd0);
    check("br2_b_flush", 32'(b_flush), 32'd2);
    check("br2_b_stall", 32'(b_stall), 32'd0);
    check("br2_a_flush", 32'(a_flush), 32'd1);
    idle_clear();

    // memBusy over a load-use hazard for 3 cycles, then the stall.
    load_use(); memBusy = 1'b1;
    look();
    check("mb0_ctrl", 32'(a_ctrl), 32'(V_MEM));
    check("mb0_state", 32'(a_state), 32'd0);
    cyc();
    look();
    check("mb1_ctrl", 32'(a_ctrl), 32'(V_MEM));
    check("mb1_state", 32'(a_state), 32'd3);
    cyc();
    look();
    check("mb2_ctrl", 32'(a_ctrl), 32'(V_MEM));
    cyc();
    memBusy = 1'b0;
    look();
    check("mb_exit_ctrl", 32'(a_ctrl), 32'(V_STALL));
    check("mb_exit_state", 32'(a_state), 32'd3);
    cyc();
    quiet();
    look();
    check("mb_done_ctrl", 32'(a_ctrl), 32'(V_DEF));
    check("mb_done_state", 32'(a_state), 32'd0);
    check("mb_stall", 32'(a_stall), 32'd4);
    check("mb_flush", 32'(a_flush), 32'd1);
    idle_clear();

    // dut_b: branch on the second of three stall cycles aborts the stall.
    load_use();
    look();
    check("ab0_ctrl", 32'(b_ctrl), 32'(V_STALL));
    cyc();
    quiet(); branchTakenEX = 1'b1;
    look();
    check("ab1_state", 32'(b_state), 32'd1);
    check("ab1_ctrl", 32'(b_ctrl), 32'(V_FLUSH));
    cyc();
    branchTakenEX = 1'b0;
    look();
    check("ab2_state", 32'(b_state), 32'd2);
    check("ab2_ctrl", 32'(b_ctrl), 32'(V_FLUSH));
    cyc();
    look();
    check("ab3_state", 32'(b_state), 32'd0);
    check("ab3_ctrl", 32'(b_ctrl), 32'(V_DEF));
    check("ab_stall", 32'(b_stall), 32'd1);
    check("ab_flush", 32'(b_flush), 32'd3);
    idle_clear();

    // Saturation and clear-over-increment.
    memBusy = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    look();
    check("sat_b_stall", 32'(b_stall), 32'd7);
    check("sat_a_stall", 32'(a_stall), 32'd10);
    cntClr = 1'b1;
    cyc();
    cntClr = 1'b0;
    look();
    check("clr_b_stall", 32'(b_stall), 32'd0);
    check("clr_a_stall", 32'(a_stall), 32'd0);
    memBusy = 1'b0;
    look();
    check("mb_release_b", 32'(b_ctrl), 32'(V_DEF));
    idle_clear();

    // Reset asserted mid-FLUSH.
    branchTakenEX = 1'b1;
    cyc();
    branchTakenEX = 1'b0;
    look();
    check("pre_rst_state", 32'(b_state), 32'd2);
    rst_n = 1'b0;
    look();
    check("mid_rst_state", 32'(b_state), 32'd0);
    check("mid_rst_stall", 32'(b_stall), 32'd0);
    check("mid_rst_flush", 32'(b_flush), 32'd0);
    check("mid_rst_ctrl", 32'(b_ctrl), 32'(V_RST));
    cyc();
    rst_n = 1'b1;
    look();
    check("rel_ctrl", 32'(b_ctrl), 32'(V_DEF));
    cyc();
    look();
    check("rel_state", 32'(b_state), 32'd0);
    check("rel_flush", 32'(b_flush), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage datapath. Sits beside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, ID-stage jump squashes and data-memory wait states. It drives the PC and IF/ID write enables, the IF/ID and ID/EX flush controls and the EX/MEM hold. It also keeps saturating stall and flush event counters for SAD-kernel profiling.

Parameters:
REG_W, 5, register-specifier width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
BRANCH_FLUSH_CYCLES, 1, cycles of IF/ID+ID/EX flush per taken branch (>=1)
CNT_W, 16, width of the profiling counters

Ports:
clk  in  1  pipeline clock, rising-edge
rst_n  in  1  asynchronous active-low reset
regRsID  in  REG_W  rs of the instruction in ID
regRtID  in  REG_W  rt of the instruction in ID
useRtID  in  1  ID instruction reads rt as a source
memReadEX  in  1  EX instruction is a load
writeRegEX  in  REG_W  destination register of the EX instruction
branchTakenEX  in  1  branch resolved taken in EX this cycle
jumpID  in  1  jump decoded in ID this cycle
memBusy  in  1  data memory not ready; whole pipeline must freeze
cntClr  in  1  synchronous clear of both counters
pcWrite  out  1  PC register load enable
ifidWrite  out  1  IF/ID register load enable
ifidFlush  out  1  IF/ID register loads a NOP
idexFlush  out  1  ID/EX register loads a bubble (control bits zero)
exmemHold  out  1  EX/MEM and MEM/WB hold their contents
stateOut  out  2  current FSM state, for debug
stallCount  out  CNT_W  cycles with pcWrite=0, saturating
flushCount  out  CNT_W  cycles with ifidFlush|idexFlush=1, saturating

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- FSM states: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3. The state register and the remaining-cycle counter (remCnt) are registered.
- Control outputs are combinational from the state and the current inputs, so they are valid in the same cycle as the hazard.
- While rst_n=0: state=RUN, remCnt=0, counters=0, pcWrite=0, ifidWrite=0, ifidFlush=1, idexFlush=1, exmemHold=0.
- Default outputs (no event): pcWrite=1, ifidWrite=1, ifidFlush=0, idexFlush=0, exmemHold=0.
- Load-use hazard (loadHaz) is true when all of the following hold:
  - memReadEX=1;
  - writeRegEX!=0;
  - writeRegEX==regRsID, or (useRtID=1 and writeRegEX==regRtID).
- Priority within a cycle: memBusy > branchTakenEX > loadHaz > jumpID.
- memBusy=1 in any state:
  - Outputs: pcWrite=0, ifidWrite=0, no flushes, exmemHold=1.
  - Next state is MEM_WAIT. The interrupted state and remCnt are saved.
  - MEM_WAIT exits to the saved state with the saved remCnt on the first cycle memBusy=0; that cycle is evaluated as the saved state.
- RUN state:
  - branchTakenEX: pcWrite=1, ifidFlush=1, idexFlush=1. If BRANCH_FLUSH_CYCLES>1, go to FLUSH with remCnt=BRANCH_FLUSH_CYCLES-1.
  - loadHaz: pcWrite=0, ifidWrite=0, idexFlush=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with remCnt=LOAD_STALL_CYCLES-1.
  - jumpID: ifidFlush=1 only, stay in RUN.
- LOAD_STALL state:
  - Outputs are the same as a loadHaz cycle.
  - remCnt decrements each cycle; the state returns to RUN after the cycle in which remCnt==1.
  - branchTakenEX here aborts the stall: apply RUN branch behaviour.
- FLUSH state:
  - pcWrite=1, ifidWrite=1, ifidFlush=1, idexFlush=1.
  - remCnt decrements; return to RUN after remCnt==1.
  - Any new branchTakenEX reloads remCnt.
- Counters:
  - stallCount increments on every non-reset cycle with pcWrite=0.
  - flushCount increments on every non-reset cycle with ifidFlush|idexFlush=1.
  - Both saturate at all-ones.
  - cntClr=1 zeroes both and takes priority over increment.
- Register 0 never causes a stall.
- Simultaneous loadHaz and jumpID: stall only, and the jump is re-presented next cycle.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN, LOAD_STALL, FLUSH, MEM_WAIT);
  - the REG_ZERO constant;
  - the default-control-vector constant.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, clr, inc, count), instantiated twice.

Test Plan:
- lw $t0 in EX (memReadEX=1, writeRegEX=8), regRsID=8 -> one cycle of pcWrite=0, ifidWrite=0, idexFlush=1, then defaults; stallCount=1.
- memReadEX=1, writeRegEX=0, regRsID=0 -> no stall; all defaults.
- BRANCH_FLUSH_CYCLES=2, branchTakenEX pulse -> two consecutive cycles with ifidFlush=idexFlush=1 and pcWrite=1; flushCount=2; stateOut 0->2->0.
- loadHaz and memBusy in the same cycle, memBusy held 3 cycles -> 3 cycles exmemHold=1, pcWrite=0, no flush; then the load-use stall cycle with idexFlush=1; stallCount=4.
- LOAD_STALL_CYCLES=3, branchTakenEX on the second stall cycle -> stall aborts, flush issued that cycle, state returns to RUN.
- Reset asserted mid-FLUSH -> immediately stateOut=0, stallCount=flushCount=0, ifidFlush=idexFlush=1; after release, defaults resume.
